// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
//   Shared switch configuration: the default switch dimensions and the scalar
//   types sized from them. vc_allocator_rr takes its parameter defaults from
//   here, so one edit reconfigures a default-sized switch.
//
//   DEF_NUM_INPORTS / DEF_NUM_OUTPORTS / DEF_NUM_VCS / DEF_BUFFER_DEPTH
//     default switch dimensions
//   CREDIT_W   width of one per-(outport, vc) credit counter
//   vc_t, outport_t, inport_t, credit_t   index / counter types
// -----------------------------------------------------------------------------
package switch_pkg;

    localparam int DEF_NUM_INPORTS  = 4;
    localparam int DEF_NUM_OUTPORTS = 4;
    localparam int DEF_NUM_VCS      = 2;
    localparam int DEF_BUFFER_DEPTH = 4;

    // Counter must hold every value 0..BUFFER_DEPTH inclusive.
    localparam int CREDIT_W = $clog2(DEF_BUFFER_DEPTH + 1);

    typedef logic [$clog2(DEF_NUM_VCS)-1:0]      vc_t;
    typedef logic [$clog2(DEF_NUM_OUTPORTS)-1:0] outport_t;
    typedef logic [$clog2(DEF_NUM_INPORTS)-1:0]  inport_t;
    typedef logic [CREDIT_W-1:0]                 credit_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. Picks the first asserted request
//   at or after ptr, wrapping around to index 0. The pointer register lives in
//   the caller.
//
//   req  in  [N]   request vector
//   ptr  in  [PW]  highest-priority index this cycle (must be < N)
//   gnt  out [N]   one-hot grant, all-zero when nothing requests
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    // Two passes over constant indices: first the upper segment [ptr, N),
    // then the wrapped segment [0, ptr). The first hit wins.
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_allocator_rr.sv
// -----------------------------------------------------------------------------
// vc_allocator_rr
//   Switch VC allocator. Keeps a credit counter per (outport, vc) for the
//   downstream buffers, tracks which inport owns each downstream VC so packets
//   never interleave on one VC, applies dateline escalation to the requested
//   VC, and arbitrates head-flit requests round-robin per outport.
//
//   clk               in   switch clock
//   n_rst             in   asynchronous active-low reset
//   req               in   [NI]       head flit requests allocation
//   req_outport       in   [NI][OP_W] routed outport of the head flit
//   req_vc            in   [NI][VC_W] current VC of the packet
//   grant             out  [NI]       allocation granted (combinational)
//   assigned_vc       out  [NI][VC_W] downstream VC, valid with grant
//   packet_sent       in   [NO][NV]   one flit sent on (outport, vc)
//   tail_sent         in   [NO][NV]   that flit is a tail (releases the VC)
//   credit_granted    in   [NO][NV]   one credit returned from downstream
//   dateline          in   [NO]       outport crosses the dateline
//   buffer_available  out  [NO][NV]   credit count nonzero
//   credit_err        out             sticky credit underflow/overflow
// -----------------------------------------------------------------------------
module vc_allocator_rr
    import switch_pkg::*;
#(
    parameter  int NUM_INPORTS  = DEF_NUM_INPORTS,
    parameter  int NUM_OUTPORTS = DEF_NUM_OUTPORTS,
    parameter  int NUM_VCS      = DEF_NUM_VCS,
    parameter  int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    localparam int IP_W = (NUM_INPORTS  > 1) ? $clog2(NUM_INPORTS)  : 1,
    localparam int OP_W = (NUM_OUTPORTS > 1) ? $clog2(NUM_OUTPORTS) : 1,
    localparam int VC_W = $clog2(NUM_VCS),
    localparam int CW   = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                                       clk,
    input  logic                                       n_rst,
    input  logic [NUM_INPORTS-1:0]                     req,
    input  logic [NUM_INPORTS-1:0][OP_W-1:0]           req_outport,
    input  logic [NUM_INPORTS-1:0][VC_W-1:0]           req_vc,
    output logic [NUM_INPORTS-1:0]                     grant,
    output logic [NUM_INPORTS-1:0][VC_W-1:0]           assigned_vc,
    input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]       packet_sent,
    input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]       tail_sent,
    input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]       credit_granted,
    input  logic [NUM_OUTPORTS-1:0]                    dateline,
    output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]       buffer_available,
    output logic                                       credit_err
);

    logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][CW-1:0]   credit_q, credit_d;
    logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]           owned_q, owned_d;
    logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][IP_W-1:0] owner_q, owner_d;
    logic [NUM_OUTPORTS-1:0][IP_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic                                           credit_err_q, credit_err_d;

    logic [NUM_INPORTS-1:0][VC_W-1:0]               tvc;
    logic [NUM_INPORTS-1:0]                         eligible;
    logic [NUM_OUTPORTS-1:0][NUM_INPORTS-1:0]       arb_req;
    logic [NUM_OUTPORTS-1:0][NUM_INPORTS-1:0]       arb_gnt;

    // Target VC: a dateline crossing bumps the VC by one, saturating at the
    // top VC. Eligibility looks only at registered state, so a VC released
    // this cycle still reads as owned and cannot be re-granted until the next.
    always_comb begin
        tvc      = '0;
        eligible = '0;
        arb_req  = '0;
        for (int i = 0; i < NUM_INPORTS; i++) begin
            tvc[i] = req_vc[i];
            if (dateline[req_outport[i]] && (req_vc[i] != VC_W'(NUM_VCS - 1))) begin
                tvc[i] = req_vc[i] + VC_W'(1);
            end
            eligible[i] = req[i]
                        && !owned_q[req_outport[i]][tvc[i]]
                        && (credit_q[req_outport[i]][tvc[i]] != '0);
            for (int o = 0; o < NUM_OUTPORTS; o++) begin
                arb_req[o][i] = eligible[i] && (req_outport[i] == OP_W'(o));
            end
        end
    end

    for (genvar go = 0; go < NUM_OUTPORTS; go++) begin : g_arb
        rr_arbiter #(
            .N   (NUM_INPORTS)
        ) u_rr_arbiter (
            .req (arb_req[go]),
            .ptr (rr_ptr_q[go]),
            .gnt (arb_gnt[go])
        );
    end

    // Each inport targets exactly one outport, so OR-ing the per-outport
    // grants never merges two winners onto one inport.
    always_comb begin
        grant = '0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            grant = grant | arb_gnt[o];
        end
    end

    assign assigned_vc = tvc;

    always_comb begin
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                buffer_available[o][v] = (credit_q[o][v] != '0);
            end
        end
    end

    assign credit_err = credit_err_q;

    always_comb begin
        credit_d     = credit_q;
        owned_d      = owned_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        credit_err_d = credit_err_q;

        // Credits: a send and a return in the same cycle cancel. Underflow
        // and overflow hold the count and raise the sticky error.
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (packet_sent[o][v] && !credit_granted[o][v]) begin
                    if (credit_q[o][v] == '0) begin
                        credit_err_d = 1'b1;
                    end else begin
                        credit_d[o][v] = credit_q[o][v] - CW'(1);
                    end
                end else if (credit_granted[o][v] && !packet_sent[o][v]) begin
                    if (credit_q[o][v] == CW'(BUFFER_DEPTH)) begin
                        credit_err_d = 1'b1;
                    end else begin
                        credit_d[o][v] = credit_q[o][v] + CW'(1);
                    end
                end
                if (packet_sent[o][v] && tail_sent[o][v]) begin
                    owned_d[o][v] = 1'b0;
                end
            end
        end

        // Grants claim the VC and move the pointer past the winner. A grant
        // never targets a VC being released, since that VC is still owned.
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            for (int i = 0; i < NUM_INPORTS; i++) begin
                if (arb_gnt[o][i]) begin
                    owned_d[o][tvc[i]] = 1'b1;
                    owner_d[o][tvc[i]] = IP_W'(i);
                    rr_ptr_d[o]        = IP_W'((i + 1) % NUM_INPORTS);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int o = 0; o < NUM_OUTPORTS; o++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    credit_q[o][v] <= CW'(BUFFER_DEPTH);
                end
            end
            owned_q      <= '0;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            credit_err_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            owned_q      <= owned_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_err_q <= credit_err_d;
        end
    end

    a_tail_needs_send : assert property (
        @(posedge clk) disable iff (!n_rst)
        ((tail_sent & ~packet_sent) == '0)
    );

    for (genvar gi = 0; gi < NUM_INPORTS; gi++) begin : g_chk
        a_outport_range : assert property (
            @(posedge clk) disable iff (!n_rst)
            req[gi] |-> (32'(req_outport[gi]) < NUM_OUTPORTS)
        );
    end

endmodule

// File: tb/tb_vc_allocator_rr.sv
module tb_vc_allocator_rr;
    import switch_pkg::*;

    localparam int NI  = DEF_NUM_INPORTS;
    localparam int NO  = DEF_NUM_OUTPORTS;
    localparam int NV  = DEF_NUM_VCS;
    localparam int BD  = DEF_BUFFER_DEPTH;
    localparam int OPW = $clog2(NO);
    localparam int VCW = $clog2(NV);

    logic                    clk = 1'b0;
    logic                    n_rst;
    logic [NI-1:0]           req;
    logic [NI-1:0][OPW-1:0]  req_outport;
    logic [NI-1:0][VCW-1:0]  req_vc;
    logic [NI-1:0]           grant;
    logic [NI-1:0][VCW-1:0]  assigned_vc;
    logic [NO-1:0][NV-1:0]   packet_sent;
    logic [NO-1:0][NV-1:0]   tail_sent;
    logic [NO-1:0][NV-1:0]   credit_granted;
    logic [NO-1:0]           dateline;
    logic [NO-1:0][NV-1:0]   buffer_available;
    logic                    credit_err;

    vc_allocator_rr dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .req              (req),
        .req_outport      (req_outport),
        .req_vc           (req_vc),
        .grant            (grant),
        .assigned_vc      (assigned_vc),
        .packet_sent      (packet_sent),
        .tail_sent        (tail_sent),
        .credit_granted   (credit_granted),
        .dateline         (dateline),
        .buffer_available (buffer_available),
        .credit_err       (credit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NI-1:0]          g;
        logic [NI-1:0][VCW-1:0] avc;
        logic [NO-1:0][NV-1:0]  ba;
        logic                   err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain integers, owner -1 means free.
    int      cred  [NO][NV];
    int      own   [NO][NV];
    int      ptr   [NO];
    bit      merr;
    bit [NI-1:0] mgrant;
    vc_t     mtvc  [NI];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    endtask

    task automatic model_reset();
        for (int o = 0; o < NO; o++) begin
            ptr[o] = 0;
            for (int v = 0; v < NV; v++) begin
                cred[o][v] = BD;
                own[o][v]  = -1;
            end
        end
        merr = 1'b0;
    endtask

    function automatic vc_t target_vc(input int i);
        int v;
        v = int'(req_vc[i]);
        if (dateline[req_outport[i]]) v = (v + 1 > NV - 1) ? NV - 1 : v + 1;
        return vc_t'(v);
    endfunction

    task automatic model_eval();
        exp_t e;
        int   i;
        int   t;
        mgrant = '0;
        for (int k = 0; k < NI; k++) mtvc[k] = target_vc(k);
        for (int o = 0; o < NO; o++) begin
            for (int k = 0; k < NI; k++) begin
                i = (ptr[o] + k) % NI;
                t = int'(mtvc[i]);
                if (req[i] && int'(req_outport[i]) == o && own[o][t] < 0 && cred[o][t] > 0) begin
                    mgrant[i] = 1'b1;
                    break;
                end
            end
        end
        e.g = mgrant;
        for (int k = 0; k < NI; k++) e.avc[k] = mtvc[k];
        for (int o = 0; o < NO; o++)
            for (int v = 0; v < NV; v++) e.ba[o][v] = (cred[o][v] > 0);
        e.err = merr;
        exp_q.push_back(e);
    endtask

    task automatic model_commit();
        int o;
        for (int oo = 0; oo < NO; oo++) begin
            for (int v = 0; v < NV; v++) begin
                if (packet_sent[oo][v] && !credit_granted[oo][v]) begin
                    if (cred[oo][v] == 0) merr = 1'b1; else cred[oo][v]--;
                end else if (credit_granted[oo][v] && !packet_sent[oo][v]) begin
                    if (cred[oo][v] == BD) merr = 1'b1; else cred[oo][v]++;
                end
                if (packet_sent[oo][v] && tail_sent[oo][v]) own[oo][v] = -1;
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (mgrant[i]) begin
                o = int'(req_outport[i]);
                own[o][int'(mtvc[i])] = i;
                ptr[o] = (i + 1) % NI;
            end
        end
    endtask

    // One clock of stimulus: predict, let the edge happen, advance the model.
    task automatic cycle();
        model_eval();
        @(posedge clk);
        #1;
        if (n_rst) model_commit();
    endtask

    task automatic clear_inputs();
        req            = '0;
        req_outport    = '0;
        req_vc         = '0;
        packet_sent    = '0;
        tail_sent      = '0;
        credit_granted = '0;
        dateline       = '0;
    endtask

    task automatic clear_link();
        packet_sent    = '0;
        tail_sent      = '0;
        credit_granted = '0;
    endtask

    // Monitor: compare every presented cycle against its queued prediction.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("grant", 64'(grant), 64'(mon_e.g));
            check("buffer_available", 64'(buffer_available), 64'(mon_e.ba));
            check("credit_err", 64'(credit_err), 64'(mon_e.err));
            for (int i = 0; i < NI; i++)
                if (mon_e.g[i]) check($sformatf("assigned_vc[%0d]", i), 64'(assigned_vc[i]), 64'(mon_e.avc[i]));
        end
    end

    initial begin
        clear_inputs();
        n_rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Reset then idle.
        cycle();
        cycle();

        // (1,1): two sends -> 2, send+return -> stays 2, two sends -> empty.
        packet_sent[1][1] = 1'b1;
        cycle(); cycle();
        credit_granted[1][1] = 1'b1;
        cycle();
        credit_granted[1][1] = 1'b0;
        cycle(); cycle();
        clear_link();
        cycle();
        credit_granted[1][1] = 1'b1;
        repeat (4) cycle();
        clear_link();

        // Dateline escalation and saturation on outport 2.
        dateline[2]    = 1'b1;
        req[0]         = 1'b1;
        req_outport[0] = 2'd2;
        req_vc[0]      = '0;
        cycle();
        req[0] = 1'b0;
        packet_sent[2][1] = 1'b1; tail_sent[2][1] = 1'b1; credit_granted[2][1] = 1'b1;
        cycle();
        clear_link();
        req[0]    = 1'b1;
        req_vc[0] = 1'b1;
        cycle();
        req[0] = 1'b0;
        packet_sent[2][1] = 1'b1; tail_sent[2][1] = 1'b1; credit_granted[2][1] = 1'b1;
        cycle();
        clear_inputs();

        // Fairness on (3,0): all four hold their request.
        for (int i = 0; i < NI; i++) begin
            req[i]         = 1'b1;
            req_outport[i] = 2'd3;
            req_vc[i]      = '0;
        end
        for (int i = 0; i < NI; i++) begin
            cycle();
            req[i] = 1'b0;
            cycle();
            packet_sent[3][0] = 1'b1; tail_sent[3][0] = 1'b1; credit_granted[3][0] = 1'b1;
            cycle();
            clear_link();
        end
        clear_inputs();

        // Ownership of (1,0) by inport 2, blocked inport 0, then reset mid-packet.
        req[2] = 1'b1; req_outport[2] = 2'd1;
        cycle();
        req[2] = 1'b0;
        req[0] = 1'b1; req_outport[0] = 2'd1;
        cycle();
        packet_sent[1][0] = 1'b1;
        cycle();
        clear_link();
        cycle();
        n_rst = 1'b0;
        model_reset();
        cycle();
        n_rst = 1'b1;
        cycle();
        req[0] = 1'b0;
        packet_sent[1][0] = 1'b1; tail_sent[1][0] = 1'b1; credit_granted[1][0] = 1'b1;
        cycle();
        clear_inputs();

        // Exhaust (0,0), then underflow it.
        packet_sent[0][0] = 1'b1;
        repeat (4) cycle();
        clear_link();
        cycle();
        packet_sent[0][0] = 1'b1;
        cycle();
        clear_link();
        cycle();
        credit_granted[0][0] = 1'b1;
        repeat (4) cycle();
        clear_link();
        cycle();

        // Fresh start, then randomized legal traffic with one mid-run reset.
        n_rst = 1'b0;
        model_reset();
        cycle();
        n_rst = 1'b1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NI; i++) begin
                req[i]         = ($urandom_range(0, 2) != 0);
                req_outport[i] = OPW'($urandom_range(0, NO - 1));
                req_vc[i]      = VCW'($urandom_range(0, NV - 1));
            end
            dateline = NO'($urandom);
            for (int o = 0; o < NO; o++) begin
                for (int v = 0; v < NV; v++) begin
                    packet_sent[o][v]    = 1'b0;
                    tail_sent[o][v]      = 1'b0;
                    credit_granted[o][v] = 1'b0;
                    if (cred[o][v] > 0 && $urandom_range(0, 3) == 0) begin
                        packet_sent[o][v] = 1'b1;
                        tail_sent[o][v]   = 1'($urandom_range(0, 1));
                    end
                    if (cred[o][v] < BD && $urandom_range(0, 2) == 0) credit_granted[o][v] = 1'b1;
                end
            end
            if (c == 200) begin
                n_rst = 1'b0;
                model_reset();
                cycle();
                n_rst = 1'b1;
            end else begin
                cycle();
            end
        end
        clear_inputs();
        cycle();

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
